// File: rtl/mdu_pkg.sv
// -----------------------------------------------------------------------------
// mdu_pkg
// Shared definitions for the RV32M issue/sequencing controller:
//   - funct3_e : RV32M funct3 encodings
//   - state_e  : controller FSM states
//   - INT_MIN / ALL_ONES : operand patterns used by the divide special cases
// -----------------------------------------------------------------------------
package mdu_pkg;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_WAIT = 2'd1,
        ST_DIV_WAIT = 2'd2,
        ST_RESP     = 2'd3
    } state_e;

    localparam logic [31:0] INT_MIN  = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_special_case.sv
// -----------------------------------------------------------------------------
// mdu_special_case
// Combinational detector for the divide results that never go to the divider:
// divide-by-zero (all four divide ops) and signed overflow (DIV/REM only).
//   funct3 in  3  : RV32M funct3 of the presented instruction
//   rs1    in 32  : dividend
//   rs2    in 32  : divisor
//   hit    out 1  : result is resolved locally
//   result out 32 : locally resolved result (0 when hit is low)
// -----------------------------------------------------------------------------
module mdu_special_case (
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        hit,
    output logic [31:0] result
);
    import mdu_pkg::*;

    logic div_by_zero;
    logic overflow;

    assign div_by_zero = (rs2 == '0);
    assign overflow    = (rs1 == INT_MIN) && (rs2 == ALL_ONES);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case statement can infer a latch.
    always_comb begin
        hit    = 1'b0;
        result = '0;
        case (funct3_e'(funct3))
            F3_DIV: begin
                if (div_by_zero) begin
                    hit    = 1'b1;
                    result = ALL_ONES;
                end else if (overflow) begin
                    hit    = 1'b1;
                    result = INT_MIN;
                end
            end
            F3_DIVU: begin
                if (div_by_zero) begin
                    hit    = 1'b1;
                    result = ALL_ONES;
                end
            end
            F3_REM: begin
                if (div_by_zero) begin
                    hit    = 1'b1;
                    result = rs1;
                end else if (overflow) begin
                    hit    = 1'b1;
                    result = '0;
                end
            end
            F3_REMU: begin
                if (div_by_zero) begin
                    hit    = 1'b1;
                    result = rs1;
                end
            end
            default: ;  // multiply ops never hit
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl
// EX-stage issue/sequencing controller for RV32M. Accepts one M instruction at
// a time, stalls the pipeline while it runs, drives an iterative multiplier
// through a start/done handshake and a combinational divider as a multicycle
// path, and returns one registered result per instruction to writeback.
//   DIV_CYCLES          : cycles the divider operands are held (1..15)
//   clk, rst_n          : clock, synchronous active-low reset
//   flush               : kills any in-flight or presented operation
//   req_*               : presented instruction (valid, funct3, rs1, rs2, rd)
//   req_ready           : high in IDLE
//   stall_o             : holds IF/ID/EX
//   mul_start/opcode/op1/op2, mul_done/result : multiplier handshake
//   div_opcode/op1/op2, div_result            : divider multicycle path
//   resp_valid/data/rd  : one-cycle writeback response (no backpressure)
// -----------------------------------------------------------------------------
module mdu_ctrl #(
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        req_valid,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic        req_ready,
    output logic        stall_o,
    output logic        mul_start,
    output logic [1:0]  mul_opcode,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic [1:0]  div_opcode,
    output logic [31:0] div_op1,
    output logic [31:0] div_op2,
    input  logic [31:0] div_result,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd
);
    import mdu_pkg::*;

    localparam logic [3:0] CNT_LOAD = 4'(DIV_CYCLES - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        mul_first_q, mul_first_d;
    logic [31:0] resp_data_q, resp_data_d;

    // Operand registers; only funct3[1:0] is needed after the accept decision.
    logic [1:0]  op_code_q;
    logic [31:0] op_rs1_q;
    logic [31:0] op_rs2_q;
    logic [4:0]  op_rd_q;

    logic        accept;
    logic        sc_hit;
    logic [31:0] sc_result;

    mdu_special_case u_special_case (
        .funct3 (req_funct3),
        .rs1    (req_rs1),
        .rs2    (req_rs2),
        .hit    (sc_hit),
        .result (sc_result)
    );

    assign req_ready = (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready && !flush;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_first_d = 1'b0;
        resp_data_d = resp_data_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!req_funct3[2]) begin
                        state_d     = ST_MUL_WAIT;
                        mul_first_d = 1'b1;
                    end else if (sc_hit) begin
                        state_d     = ST_RESP;
                        resp_data_d = sc_result;
                    end else begin
                        state_d = ST_DIV_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_MUL_WAIT: begin
                // The start cycle may still see a done left over from an
                // abandoned operation, so done is only honoured afterwards.
                if (!mul_first_q && mul_done) begin
                    state_d     = ST_RESP;
                    resp_data_d = mul_result;
                end
            end
            ST_DIV_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d     = ST_RESP;
                    resp_data_d = div_result;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (flush) begin
            state_d     = ST_IDLE;
            mul_first_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of code order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            mul_first_q <= 1'b0;
            resp_data_q <= '0;
            op_code_q   <= '0;
            op_rs1_q    <= '0;
            op_rs2_q    <= '0;
            op_rd_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_first_q <= mul_first_d;
            resp_data_q <= resp_data_d;
            if (accept) begin
                op_code_q <= req_funct3[1:0];
                op_rs1_q  <= req_rs1;
                op_rs2_q  <= req_rs2;
                op_rd_q   <= req_rd;
            end
        end
    end

    assign stall_o    = (state_q == ST_MUL_WAIT) || (state_q == ST_DIV_WAIT) ||
                        ((state_q == ST_IDLE) && req_valid && !flush);

    assign mul_start  = (state_q == ST_MUL_WAIT) && mul_first_q;
    assign mul_opcode = op_code_q;
    assign mul_op1    = op_rs1_q;
    assign mul_op2    = op_rs2_q;

    assign div_opcode = op_code_q;
    assign div_op1    = op_rs1_q;
    assign div_op2    = op_rs2_q;

    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;
    assign resp_rd    = op_rd_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl
// Self-checking bench for mdu_ctrl: a directed vector table, randomized
// operations checked against an RV32M arithmetic model, and hand-written
// sequences for flush and reset corner cases.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

    localparam int DIV_CYCLES = 4;
    localparam int BUDGET     = 40;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1, req_rs2;
    logic [4:0]  req_rd;
    logic        req_ready, stall_o;
    logic        mul_start;
    logic [1:0]  mul_opcode;
    logic [31:0] mul_op1, mul_op2;
    logic        mul_done;
    logic [31:0] mul_result;
    logic [1:0]  div_opcode;
    logic [31:0] div_op1, div_op2;
    logic [31:0] div_result;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mdu_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_funct3 (req_funct3),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_rd     (req_rd),
        .req_ready  (req_ready),
        .stall_o    (stall_o),
        .mul_start  (mul_start),
        .mul_opcode (mul_opcode),
        .mul_op1    (mul_op1),
        .mul_op2    (mul_op2),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .div_opcode (div_opcode),
        .div_op1    (div_op1),
        .div_op2    (div_op2),
        .div_result (div_result),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd)
    );

    // RV32M architectural result, computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_m(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint sa, sb, q;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        q  = 0;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                q = sa / sb; return q[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                q = sa % sb; return q[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Divider model: purely combinational on the controller's operands.
    assign div_result = ref_m({1'b1, div_opcode}, div_op1, div_op2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are driven here.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  rd;
        int          k;        // mul_done this many cycles after mul_start
        logic [31:0] exp_data;
        int          exp_lat;  // cycles from accept to resp_valid
    } vec_t;

    // Presents one request at the current cycle and follows it to its response.
    task automatic run_vec(input vec_t v, input string tag);
        int rel, start_rel, starts, resp_rel, stall_bad, op_bad;
        logic [31:0] got_data;
        logic [4:0]  got_rd;
        logic [31:0] mres;
        mres       = '0;
        got_data   = '0;
        got_rd     = '0;
        flush      = 1'b0;
        mul_done   = 1'b0;
        req_valid  = 1'b1;
        req_funct3 = v.f3;
        req_rs1    = v.rs1;
        req_rs2    = v.rs2;
        req_rd     = v.rd;
        @(negedge clk);
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_stall_T"}, 32'(stall_o), 32'd1);
        next_cycle();
        // Scramble the request bus so only latched operands can be used.
        req_valid  = 1'b0;
        req_funct3 = 3'($urandom);
        req_rs1    = $urandom;
        req_rs2    = $urandom;
        req_rd     = 5'($urandom);
        rel = 1; start_rel = -1; starts = 0; resp_rel = -1;
        stall_bad = 0; op_bad = 0;
        while (rel <= BUDGET && resp_rel < 0) begin
            if (!v.f3[2] && rel == 1) begin
                // Stale done in the start cycle must be ignored.
                mul_done   = 1'b1;
                mul_result = $urandom;
            end else if (start_rel >= 0 && rel == start_rel + v.k) begin
                mul_done   = 1'b1;
                mul_result = mres;
            end else begin
                mul_done   = 1'b0;
                mul_result = $urandom;
            end
            @(negedge clk);
            if (mul_start) begin
                starts++;
                if (start_rel < 0) begin
                    start_rel = rel;
                    mres = ref_m({1'b0, mul_opcode}, mul_op1, mul_op2);
                end
            end
            if (div_op1 !== v.rs1 || div_op2 !== v.rs2 || div_opcode !== v.f3[1:0] ||
                mul_op1 !== v.rs1 || mul_op2 !== v.rs2 || mul_opcode !== v.f3[1:0])
                op_bad++;
            if (resp_valid) begin
                resp_rel = rel;
                got_data = resp_data;
                got_rd   = resp_rd;
                if (stall_o) stall_bad++;
            end else if (!stall_o) begin
                stall_bad++;
            end
            next_cycle();
            rel++;
        end
        mul_done = 1'b0;
        if (resp_rel < 0) begin
            check({tag, "_resp_timeout"}, 32'd0, 32'd1);
        end else begin
            check({tag, "_data"}, got_data, v.exp_data);
            check({tag, "_rd"}, 32'(got_rd), 32'(v.rd));
            check({tag, "_latency"}, resp_rel, v.exp_lat);
            check({tag, "_stall"}, stall_bad, 0);
            check({tag, "_operands"}, op_bad, 0);
            check({tag, "_mul_starts"}, starts, v.f3[2] ? 0 : 1);
            if (!v.f3[2]) check({tag, "_start_cycle"}, start_rel, 1);
            @(negedge clk);
            check({tag, "_single_resp"}, 32'(resp_valid), 32'd0);
            check({tag, "_back_idle"}, 32'(req_ready), 32'd1);
            next_cycle();
        end
    endtask

    function automatic int model_latency(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] b, input int k);
        if (!f3[2]) return k + 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return DIV_CYCLES + 1;
    endfunction

    vec_t tbl[12];
    vec_t rv;
    int   bad;

    initial begin
        tbl[0]  = '{3'd5, 32'd100,        32'd7,          5'd5,  0, 32'd14,         5};
        tbl[1]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd1,  0, 32'h8000_0000,  1};
        tbl[2]  = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd2,  0, 32'h0000_0000,  1};
        tbl[3]  = '{3'd7, 32'h0000_1234,  32'd0,          5'd3,  0, 32'h0000_1234,  1};
        tbl[4]  = '{3'd4, 32'd5,          32'd0,          5'd4,  0, 32'hFFFF_FFFF,  1};
        tbl[5]  = '{3'd0, 32'd3,          32'hFFFF_FFFE,  5'd6,  3, 32'hFFFF_FFFA,  5};
        tbl[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd7,  0, 32'hFFFF_FFFD,  5};
        tbl[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd8,  0, 32'hFFFF_FFFF,  5};
        tbl[8]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd9,  1, 32'hFFFF_FFFE,  3};
        tbl[9]  = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF,  5'd10, 0, 32'h0000_0000,  5};
        tbl[10] = '{3'd7, 32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 0, 32'h8000_0000,  5};
        tbl[11] = '{3'd1, 32'h8000_0000,  32'h8000_0000,  5'd31, 2, 32'h4000_0000,  4};

        rst_n = 1'b0; flush = 1'b0; mul_done = 1'b0; mul_result = '0;
        // A request held during reset must be ignored.
        req_valid = 1'b1; req_funct3 = 3'd5; req_rs1 = 32'd10; req_rs2 = 32'd2; req_rd = 5'd3;
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data", resp_data, 32'd0);
        check("rst_mul_start", 32'(mul_start), 32'd0);
        check("rst_div_op1", div_op1, 32'd0);
        next_cycle();
        req_valid = 1'b0;
        rst_n = 1'b1;
        bad = 0;
        repeat (8) begin
            @(negedge clk);
            if (resp_valid || !req_ready) bad++;
            next_cycle();
        end
        check("rst_req_ignored", bad, 0);

        // Directed table.
        foreach (tbl[i]) run_vec(tbl[i], $sformatf("tbl%0d", i));

        // Flush at T+2 of a divide, then an immediate new request at T+3.
        req_valid = 1'b1; req_funct3 = 3'd5; req_rs1 = 32'd50; req_rs2 = 32'd3; req_rd = 5'd12;
        next_cycle();                      // T+1
        req_valid = 1'b0;
        bad = 0;
        @(negedge clk); if (resp_valid || !stall_o) bad++;
        next_cycle();                      // T+2
        flush = 1'b1;
        @(negedge clk); if (resp_valid) bad++;
        next_cycle();                      // T+3
        flush = 1'b0;
        check("flush_div_quiet", bad, 0);
        rv = '{3'd5, 32'd1000, 32'd9, 5'd13, 0, 32'd111, 5};
        run_vec(rv, "after_flush");

        // Flush coinciding with a presented request drops it.
        req_valid = 1'b1; flush = 1'b1; req_funct3 = 3'd4; req_rs1 = 32'd9; req_rs2 = 32'd3;
        @(negedge clk);
        check("flush_req_stall", 32'(stall_o), 32'd0);
        next_cycle();
        req_valid = 1'b0; flush = 1'b0;
        bad = 0;
        repeat (7) begin
            @(negedge clk);
            if (resp_valid || !req_ready) bad++;
            next_cycle();
        end
        check("flush_req_dropped", bad, 0);

        // Flush in RESP does not suppress the response already showing.
        req_valid = 1'b1; req_funct3 = 3'd4; req_rs1 = 32'd5; req_rs2 = 32'd0; req_rd = 5'd14;
        next_cycle();
        req_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_resp_valid", 32'(resp_valid), 32'd1);
        check("flush_resp_data", resp_data, 32'hFFFF_FFFF);
        next_cycle();
        flush = 1'b0;
        @(negedge clk);
        check("flush_resp_idle", 32'(req_ready) & ~32'(resp_valid), 32'd1);
        next_cycle();

        // Reset held mid-MUL_WAIT, then a stray mul_done after release.
        req_valid = 1'b1; req_funct3 = 3'd0; req_rs1 = 32'd7; req_rs2 = 32'd6; req_rd = 5'd15;
        next_cycle();                      // T+1: MUL_WAIT, start
        req_valid = 1'b0;
        @(negedge clk);
        check("rstmul_start", 32'(mul_start), 32'd1);
        next_cycle();                      // T+2
        rst_n = 1'b0;
        repeat (2) next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstmul_outs", {mul_op1 | mul_op2 | div_op1 | div_op2 | resp_data} |
              32'({mul_opcode, div_opcode, resp_rd, resp_valid, mul_start, stall_o}), 32'd0);
        check("rstmul_ready", 32'(req_ready), 32'd1);
        next_cycle();
        mul_done = 1'b1; mul_result = 32'd42;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid) bad++;
            next_cycle();
            mul_done = 1'b0;
        end
        check("rstmul_stray_done", bad, 0);

        // Randomized operations against the arithmetic model.
        for (int n = 0; n < 40; n++) begin
            rv.f3  = 3'($urandom);
            rv.rs1 = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 5))
                0:       rv.rs2 = 32'd0;
                1:       rv.rs2 = 32'hFFFF_FFFF;
                2:       rv.rs2 = 32'($urandom_range(1, 20));
                default: rv.rs2 = $urandom;
            endcase
            rv.rd       = 5'($urandom);
            rv.k        = $urandom_range(1, 5);
            rv.exp_data = ref_m(rv.f3, rv.rs1, rv.rs2);
            rv.exp_lat  = model_latency(rv.f3, rv.rs1, rv.rs2, rv.k);
            run_vec(rv, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

M-extension issue and sequencing controller in the EX stage of the RV32IM pipeline. It accepts one decoded M instruction at a time from ID/EX and stalls the pipeline while the operation runs. It steers MUL-class operations to the iterative multiplier through a start/done handshake. DIV-class operations go to the combinational `divider_32bit` as a multicycle path; divide-by-zero and signed overflow are resolved locally, and one registered result per instruction is returned to writeback.

## Interface
- `DIV_CYCLES`, default 4: cycles the divider operands are held before its result is sampled (legal range 1..15).
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous and active-low; one clock domain.
- `flush` in 1: kills any in-flight or presented operation.
- `req_valid` in 1: an M instruction is presented.
- `req_funct3` in 3: RV32M funct3.
- `req_rs1` in 32, `req_rs2` in 32: source operands.
- `req_rd` in 5: destination register.
- `req_ready` out 1: high when in IDLE.
- `stall_o` out 1: holds IF/ID/EX.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_opcode` out 2: `funct3[1:0]`.
- `mul_op1` out 32, `mul_op2` out 32: multiplier operands.
- `mul_done` in 1, `mul_result` in 32: multiplier completion and result.
- `div_opcode` out 2: `funct3[1:0]` (00 DIV, 01 DIVU, 10 REM, 11 REMU).
- `div_op1` out 32, `div_op2` out 32: divider operands.
- `div_result` in 32: divider result.
- `resp_valid` out 1, `resp_data` out 32, `resp_rd` out 5: writeback response. There is no backpressure; writeback always accepts.

## Operation
- **States:** IDLE, MUL_WAIT, DIV_WAIT, RESP.
- **Accept:** occurs when `req_valid & req_ready & !flush`.
  - Latch funct3, rs1, rs2 and rd into operand registers.
  - The `div_*` and `mul_*` operand outputs are driven from these registers only.
- **IDLE on accept:**
  - funct3[2]=0: go to MUL_WAIT.
  - funct3[2]=1 and a special case applies: compute the result locally and go to RESP.
  - funct3[2]=1 otherwise: load the counter with DIV_CYCLES-1 and go to DIV_WAIT.
- **Special cases** (evaluated on the request operands):
  - rs2==0: DIV and DIVU return 0xFFFFFFFF; REM and REMU return rs1.
  - DIV with rs1==0x80000000 and rs2==0xFFFFFFFF returns 0x80000000.
  - REM with the same operands returns 0.
  - DIVU and REMU never overflow.
- **MUL_WAIT:**
  - `mul_start` pulses high only in the first MUL_WAIT cycle.
  - `mul_done` is sampled only in later cycles.
  - On `mul_done`, capture `mul_result` and go to RESP.
- **DIV_WAIT:**
  - When the counter is 0, capture `div_result` and go to RESP; otherwise decrement the counter.
  - The operand registers and `div_opcode` are stable for the whole state.
- **RESP:** `resp_valid`=1 for exactly one cycle, then return to IDLE.
- **Flush:**
  - In any state, the next state is IDLE with no `resp_valid`.
  - A flush coinciding with `req_valid` drops the request.
  - A flush during MUL_WAIT abandons the multiplier result, and any late `mul_done` in IDLE is ignored.
  - Flush in RESP does not suppress the response already asserted in that cycle.
- **stall_o:** high when in MUL_WAIT or DIV_WAIT, or in IDLE with `req_valid & !flush`; low in RESP and IDLE otherwise.

## Timing
- **Reset:**
  - Reset puts the FSM in IDLE and sets every registered output, counter and operand register to 0.
  - `req_ready`=1 in IDLE, but requests are ignored while `rst_n`=0.
  - Reset mid-operation discards the operation with no response.
- **Latency, with the request accepted at cycle T:**
  - Special-case path: `resp_valid` at T+1.
  - Divide path: DIV_WAIT occupies T+1..T+DIV_CYCLES, and `resp_valid` is at T+DIV_CYCLES+1 (T+5 at the default).
  - Multiply path: `mul_start` at T+1; if `mul_done` arrives at cycle D (D ≥ T+2), `resp_valid` is at D+1.
- **Back-to-back:** the earliest next accept is the cycle after RESP.
- **Width rules:**
  - All datapaths are 32-bit; there is no internal arithmetic beyond the equality compares.
  - The counter is 4 bits.

## Structure
- **`mdu_pkg` (shared package):**
  - funct3 enum: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - FSM state enum.
  - Constants: INT_MIN=0x80000000, ALL_ONES=0xFFFFFFFF.
- **`mdu_special_case` (one combinational sub-module):**
  - Inputs: funct3, rs1, rs2.
  - Outputs: a hit flag and a 32-bit result.
- **`mdu_ctrl`:** holds the FSM, counter, operand registers and response register.

## Test plan
- DIVU 100/7 with DIV_CYCLES=4 and `div_result` modelled by the divider: `stall_o` high T..T+4; `resp_valid` at T+5 with `resp_data`=14 and `resp_rd` matching.
- DIV with rs1=0x80000000, rs2=0xFFFFFFFF: `resp_data`=0x80000000 at T+1, with no DIV_WAIT cycles. Then REM with the same operands returns 0 at T+1.
- Divide by zero, REMU rs1=0x1234, rs2=0: `resp_data`=0x1234 at T+1. DIV with 5/0 returns 0xFFFFFFFF.
- MUL 3×−2 with `mul_done` driven 3 cycles after `mul_start`: a single `mul_start` pulse at T+1, and `resp_data`=0xFFFFFFFA one cycle after `mul_done`.
- Flush at T+2 of a divide: IDLE at T+3 with no `resp_valid`. A new request at T+3 is accepted and completes normally.
- Reset held mid-MUL_WAIT, then released: all outputs are 0, and a stray `mul_done` after the release produces no response.
